// File: rtl/camera_stream_pkg.sv
// Shared types and constants for the synthetic camera stream generator.
package camera_stream_pkg;

   typedef enum logic [2:0] {
      S_idle,
      S_vgap,
      S_vpre,
      S_line,
      S_hblank,
      S_vpost
   } state_t;

   localparam logic [1:0] PAT_X     = 2'b00;
   localparam logic [1:0] PAT_Y     = 2'b01;
   localparam logic [1:0] PAT_XOR   = 2'b10;
   localparam logic [1:0] PAT_FRAME = 2'b11;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/camera_pattern_gen.sv
// Test-pattern pixel source: holds the per-frame pattern select and decodes
// the pixel value from the registered line/column/frame counters.
module camera_pattern_gen
   import camera_stream_pkg::*;
#(
   parameter int PIX_W = 8,
   parameter int XW    = 1,
   parameter int YW    = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             latch_i,
   input  logic [1:0]       pattern_i,
   input  logic [XW-1:0]    x_i,
   input  logic [YW-1:0]    y_i,
   input  logic [15:0]      frame_count_i,
   input  logic             active_i,
   output logic [PIX_W-1:0] pixel_o
);

   localparam int MW = (XW > YW) ? XW : YW;

   logic [1:0] pat_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         pat_q <= PAT_X;
      end else if (latch_i) begin
         pat_q <= pattern_i;
      end
   end

   always_comb begin
      pixel_o = '0;
      if (active_i) begin
         case (pat_q)
            PAT_X:     pixel_o = PIX_W'(x_i);
            PAT_Y:     pixel_o = PIX_W'(y_i);
            PAT_XOR:   pixel_o = PIX_W'(MW'(x_i) ^ MW'(y_i));
            PAT_FRAME: pixel_o = PIX_W'(frame_count_i);
            default:   pixel_o = '0;
         endcase
      end
   end

endmodule

// File: rtl/camera_stream_generator.sv
// Synthetic camera source: continuous VS/HS/pixel frames while enabled,
// outputs decoded purely from registered state and counters.
module camera_stream_generator
   import camera_stream_pkg::*;
#(
   parameter int PIX_W    = 8,
   parameter int H_ACTIVE = 640,
   parameter int H_BLANK  = 16,
   parameter int V_ACTIVE = 480,
   parameter int V_PRE    = 8,
   parameter int V_POST   = 8,
   parameter int V_GAP    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [1:0]       pattern,
   output logic             VS,
   output logic             HS,
   output logic [PIX_W-1:0] pixel,
   output logic             frame_done,
   output logic [15:0]      frame_count
);

   localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int unsigned DMAX = max2(max2(max2(V_GAP, V_PRE), max2(V_POST, H_BLANK)), H_ACTIVE);
   localparam int CW = $clog2(DMAX + 1);

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;
   logic          frame_done_q;
   logic [15:0]   frame_count_q;
   logic          latch;

   assign latch = (state_q == S_vgap) && (cnt_q == '0) && enable;

   // Down-counter per phase; leaving idle loads V_GAP (not V_GAP-1) so the
   // first VS rise lands V_GAP+1 edges after enable is seen.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_idle;
         cnt_q         <= '0;
         x_q           <= '0;
         y_q           <= '0;
         frame_done_q  <= 1'b0;
         frame_count_q <= '0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            S_idle: begin
               if (enable) begin
                  state_q <= S_vgap;
                  cnt_q   <= CW'(V_GAP);
               end
            end
            S_vgap: begin
               if (cnt_q == '0) begin
                  if (enable) begin
                     state_q <= S_vpre;
                     cnt_q   <= CW'(V_PRE - 1);
                  end else begin
                     state_q <= S_idle;
                  end
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            S_vpre: begin
               if (cnt_q == '0) begin
                  state_q <= S_line;
                  x_q     <= '0;
                  y_q     <= '0;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            S_line: begin
               if (x_q == XW'(H_ACTIVE - 1)) begin
                  x_q <= '0;
                  if (y_q == YW'(V_ACTIVE - 1)) begin
                     state_q <= S_vpost;
                     cnt_q   <= CW'(V_POST - 1);
                  end else begin
                     state_q <= S_hblank;
                     cnt_q   <= CW'(H_BLANK - 1);
                  end
               end else begin
                  x_q <= x_q + XW'(1);
               end
            end
            S_hblank: begin
               if (cnt_q == '0) begin
                  state_q <= S_line;
                  y_q     <= y_q + YW'(1);
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            S_vpost: begin
               if (cnt_q == '0) begin
                  state_q       <= S_vgap;
                  cnt_q         <= CW'(V_GAP - 1);
                  frame_done_q  <= 1'b1;
                  frame_count_q <= frame_count_q + 16'd1;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: state_q <= S_idle;
         endcase
      end
   end

   assign VS          = (state_q == S_vpre) || (state_q == S_line) ||
                        (state_q == S_hblank) || (state_q == S_vpost);
   assign HS          = (state_q == S_line);
   assign frame_done  = frame_done_q;
   assign frame_count = frame_count_q;

   camera_pattern_gen #(
      .PIX_W (PIX_W),
      .XW    (XW),
      .YW    (YW)
   ) u_pattern (
      .clk           (clk),
      .reset         (reset),
      .latch_i       (latch),
      .pattern_i     (pattern),
      .x_i           (x_q),
      .y_i           (y_q),
      .frame_count_i (frame_count_q),
      .active_i      (HS),
      .pixel_o       (pixel)
   );

endmodule

// File: tb/tb_camera_stream_generator.sv
// Directed bench for camera_stream_generator with a small frame geometry:
// 4 pixels x 3 lines, blank 2, pre 2, post 2, gap 3 (VS high 20, period 23).
module tb_camera_stream_generator;
   import camera_stream_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [1:0]  pattern;
   logic        VS;
   logic        HS;
   logic [7:0]  pixel;
   logic        frame_done;
   logic [15:0] frame_count;
   logic        vs_prev = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;
   int lows;

   always #5 clk = ~clk;

   camera_stream_generator #(
      .PIX_W    (8),
      .H_ACTIVE (4),
      .H_BLANK  (2),
      .V_ACTIVE (3),
      .V_PRE    (2),
      .V_POST   (2),
      .V_GAP    (3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .pattern     (pattern),
      .VS          (VS),
      .HS          (HS),
      .pixel       (pixel),
      .frame_done  (frame_done),
      .frame_count (frame_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_pix(input logic [1:0] pat, input int x, input int y,
                                          input logic [15:0] fc);
      logic [7:0] xv, yv;
      xv = 8'(x);
      yv = 8'(y);
      case (pat)
         PAT_X:   return xv;
         PAT_Y:   return yv;
         PAT_XOR: return xv ^ yv;
         default: return fc[7:0];
      endcase
   endfunction

   // Counts further VS-low samples until VS goes high (bounded).
   task automatic wait_vs_high(output int n);
      n = 0;
      forever begin
         @(negedge clk);
         if (VS === 1'b1) break;
         n++;
         if (n >= 50) break;
      end
   endtask

   // Called on the first VS-high sample; checks the whole frame and its end.
   task automatic capture(input logic [1:0] pat, input logic [15:0] fc, input int sw_at,
                          input logic [1:0] sw_pat, input logic sw_en);
      int p, q, xe, ye;
      logic hs_e;
      logic [7:0] pe;
      p = 0;
      while (VS === 1'b1 && p < 100) begin
         xe = 0; ye = 0; hs_e = 1'b0;
         if (p >= 2 && p < 18) begin
            q    = p - 2;
            ye   = q / 6;
            xe   = q % 6;
            hs_e = (xe < 4);
         end
         pe = hs_e ? exp_pix(pat, xe, ye, fc) : 8'h00;
         chk($sformatf("frame fc=%0h p=%0d {HS,done,pix}", fc, p),
             {22'b0, HS, frame_done, pixel}, {22'b0, hs_e, 1'b0, pe});
         if (p == sw_at) begin
            pattern = sw_pat;
            enable  = sw_en;
         end
         @(negedge clk);
         p++;
      end
      chk("VS high length", p, 20);
      chk("frame_done pulse", {31'b0, frame_done}, 1);
      chk("frame_count after frame", {16'b0, frame_count}, {16'b0, 16'(fc + 16'd1)});
   endtask

   always @(negedge clk) begin
      if (reset === 1'b0) begin
         n_assert++;
         assert (!(HS && !VS) && (HS || pixel == 8'h00) && !(VS && !vs_prev && HS)) else begin
            n_fail++;
            $error("FAIL invariant: VS=%b HS=%b pixel=%0h prevVS=%b", VS, HS, pixel, vs_prev);
         end
      end
      vs_prev = VS;
   end

   initial begin
      int highs, dones;
      reset = 1'b1; enable = 1'b0; pattern = PAT_X;
      repeat (2) @(negedge clk);
      chk("reset VS", {31'b0, VS}, 0);
      chk("reset HS", {31'b0, HS}, 0);
      chk("reset pixel", {24'b0, pixel}, 0);
      chk("reset frame_done", {31'b0, frame_done}, 0);
      chk("reset frame_count", {16'b0, frame_count}, 0);

      // First frame from idle: 1+V_GAP = 4 low samples before VS.
      reset = 1'b0; enable = 1'b1;
      wait_vs_high(lows);
      chk("idle-to-VS latency", lows, 4);
      capture(PAT_X, 16'd0, -1, PAT_X, 1'b1);

      // Back-to-back frames: gap of 3, pattern Y switched to XOR mid-frame.
      pattern = PAT_Y;
      wait_vs_high(lows);
      chk("gap length 1", lows + 1, 3);
      capture(PAT_Y, 16'd1, 8, PAT_XOR, 1'b1);
      wait_vs_high(lows);
      chk("gap length 2", lows + 1, 3);
      // XOR frame; enable dropped during line 1, frame must still complete.
      capture(PAT_XOR, 16'd2, 9, PAT_XOR, 1'b0);

      highs = 0; dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (VS === 1'b1) highs++;
         if (frame_done === 1'b1) dones++;
      end
      chk("parked VS highs", highs, 0);
      chk("parked frame_done", dones, 0);
      chk("parked frame_count", {16'b0, frame_count}, 3);
      chk("parked state", 32'(dut.state_q), 32'(S_idle));

      // Reset in the middle of line 0.
      enable = 1'b1; pattern = PAT_X;
      wait_vs_high(lows);
      chk("restart latency", lows, 4);
      repeat (3) @(negedge clk);
      chk("pre-reset HS", {31'b0, HS}, 1);
      chk("pre-reset pixel", {24'b0, pixel}, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("midframe reset VS", {31'b0, VS}, 0);
      chk("midframe reset HS", {31'b0, HS}, 0);
      chk("midframe reset pixel", {24'b0, pixel}, 0);
      chk("midframe reset frame_done", {31'b0, frame_done}, 0);
      chk("midframe reset frame_count", {16'b0, frame_count}, 0);
      reset = 1'b0;
      wait_vs_high(lows);
      chk("post-reset latency", lows, 4);
      capture(PAT_X, 16'd0, -1, PAT_X, 1'b1);

      // Frame-count pattern across the 16-bit wrap (count preset in the gap).
      pattern = PAT_FRAME;
      force dut.frame_count_q = 16'hFFFE;
      #1;
      release dut.frame_count_q;
      wait_vs_high(lows);
      chk("gap length 3", lows + 1, 3);
      capture(PAT_FRAME, 16'hFFFE, -1, PAT_FRAME, 1'b1);
      wait_vs_high(lows);
      capture(PAT_FRAME, 16'hFFFF, -1, PAT_FRAME, 1'b1);
      chk("frame_count wrapped", {16'b0, frame_count}, 0);
      wait_vs_high(lows);
      capture(PAT_FRAME, 16'h0000, -1, PAT_FRAME, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
